// File: rtl/abr_ram_pkg.sv
// abr_ram_pkg -- shared types and constants for the 1R1W zeroizable RAM.
//   abr_zram_state_e        : zeroize controller FSM state encoding
//   READ_LATENCY_MIN/MAX    : legal range of the READ_LATENCY parameter
//   read_latency_legal()    : elaboration-time range check helper
package abr_ram_pkg;

  typedef enum logic [1:0] {
    ZRAM_IDLE  = 2'd0,
    ZRAM_SWEEP = 2'd1,
    ZRAM_DONE  = 2'd2
  } abr_zram_state_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 2;

  function automatic bit read_latency_legal(int unsigned lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/abr_1r1w_zeroize_ram_ctrl.sv
// abr_1r1w_zeroize_ram_ctrl -- zeroize FSM and sweep address counter.
// Ports:
//   clk_i, rst_i      : clock (rising edge), async active-high reset
//   zeroize_i         : request a full-array clear (honoured only in IDLE)
//   idle_o            : FSM is IDLE, user reads/writes may be accepted
//   sweep_we_o        : write zero to sweep_addr_o this cycle
//   sweep_addr_o      : current sweep address
//   busy_o            : sweep in progress (SWEEP or DONE), registered
//   zeroize_done_o    : one-cycle pulse in DONE, registered
// A sweep lasts DEPTH cycles in SWEEP plus one in DONE.
module abr_1r1w_zeroize_ram_ctrl
  import abr_ram_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  zeroize_i,
  output logic                  idle_o,
  output logic                  sweep_we_o,
  output logic [ADDR_WIDTH-1:0] sweep_addr_o,
  output logic                  busy_o,
  output logic                  zeroize_done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  abr_zram_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ZRAM_IDLE: begin
        if (zeroize_i) begin
          state_d = ZRAM_SWEEP;
          cnt_d   = '0;
        end
      end
      ZRAM_SWEEP: begin
        // Counter naturally wraps to 0 on the last word; DEPTH is a power of two.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ZRAM_DONE;
      end
      ZRAM_DONE: state_d = ZRAM_IDLE;
      default:   state_d = ZRAM_IDLE;
    endcase
    // Outputs are registered from the next state so they align with state_q.
    busy_d = (state_d != ZRAM_IDLE);
    done_d = (state_d == ZRAM_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ZRAM_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign idle_o         = (state_q == ZRAM_IDLE);
  assign sweep_we_o     = (state_q == ZRAM_SWEEP);
  assign sweep_addr_o   = cnt_q;
  assign busy_o         = busy_q;
  assign zeroize_done_o = done_q;

endmodule

// File: rtl/abr_1r1w_zeroize_ram.sv
// abr_1r1w_zeroize_ram -- one-read/one-write RAM with a full-array zeroize sweep.
// Ports:
//   clk_i, rst_i               : clock (rising edge), async active-high reset
//   we_i, waddr_i, wdata_i     : write port (accepted only while idle)
//   re_i, raddr_i              : read request (accepted only while idle)
//   rdata_o, rvalid_o          : read data, valid pulse READ_LATENCY cycles later
//   zeroize_i                  : start clearing the whole array
//   busy_o, zeroize_done_o     : sweep in progress / sweep-complete pulse
// Configuration macro: ABR_RAM_WR_BYPASS_EN -- when defined, a read that
// collides with a same-cycle write returns the new data (write-first);
// otherwise the old contents are returned (read-first).
// The storage array itself is never reset; rst_i only clears control/pipeline.
module abr_1r1w_zeroize_ram
  import abr_ram_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic                  zeroize_i,
  output logic                  busy_o,
  output logic                  zeroize_done_o
);

  if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
    $error("abr_1r1w_zeroize_ram: READ_LATENCY must be 1 or 2");
  end

  logic                  idle;
  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr;

  abr_1r1w_zeroize_ram_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .zeroize_i      (zeroize_i),
    .idle_o         (idle),
    .sweep_we_o     (sweep_we),
    .sweep_addr_o   (sweep_addr),
    .busy_o         (busy_o),
    .zeroize_done_o (zeroize_done_o)
  );

  // zeroize_i wins over same-cycle user traffic.
  logic zstart, rd_acc, wr_acc;
  assign zstart = idle & zeroize_i;
  assign rd_acc = idle & re_i & ~zeroize_i;
  assign wr_acc = idle & we_i & ~zeroize_i;

  // Storage: single write port shared between user writes and the sweep.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = wr_acc | sweep_we;
    mem_waddr = sweep_we ? sweep_addr : waddr_i;
    mem_wdata = sweep_we ? '0 : wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic [DATA_WIDTH-1:0] rd_word;
`ifdef ABR_RAM_WR_BYPASS_EN
  assign rd_word = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
`else
  assign rd_word = mem[raddr_i];
`endif

  // Stage 1: array output register. Holds when idle, cleared on sweep entry.
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  v1_q, v1_d;

  always_comb begin
    rd1_d = rd1_q;
    if (rd_acc)      rd1_d = rd_word;
    else if (zstart) rd1_d = '0;
    v1_d = rd_acc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd1_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      v1_q  <= v1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    // Stage 2 only advances on a valid stage-1 beat, so data holds between reads
    // and a read still in flight at sweep entry is dropped.
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic                  v2_q, v2_d;

    always_comb begin
      rd2_d = rd2_q;
      if (zstart)    rd2_d = '0;
      else if (v1_q) rd2_d = rd1_q;
      v2_d = v1_q & ~zstart;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd2_q <= '0;
        v2_q  <= 1'b0;
      end else begin
        rd2_q <= rd2_d;
        v2_q  <= v2_d;
      end
    end

    assign rdata_o  = rd2_q;
    assign rvalid_o = v2_q;
  end else begin : g_lat1
    assign rdata_o  = rd1_q;
    assign rvalid_o = v1_q;
  end

endmodule

// File: tb/tb_abr_1r1w_zeroize_ram.sv
module tb_abr_1r1w_zeroize_ram;

  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, re, zeroize;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid1, rvalid2, busy1, busy2, done1, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  abr_1r1w_zeroize_ram #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata1), .rvalid_o(rvalid1),
    .zeroize_i(zeroize), .busy_o(busy1), .zeroize_done_o(done1)
  );

  abr_1r1w_zeroize_ram #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata2), .rvalid_o(rvalid2),
    .zeroize_i(zeroize), .busy_o(busy2), .zeroize_done_o(done2)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; re = 0; zeroize = 0; waddr = '0; raddr = '0; wdata = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  // LAT=1 read: returns data seen one edge after re_i, with its valid flag.
  task automatic rd1(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    re = 1; raddr = a;
    tick();
    re = 0;
    d = rdata1; v = rvalid1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    checks++;
    if ({rvalid1, busy1, done1, rvalid2, busy2, done2} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=000000", {rvalid1, busy1, done1, rvalid2, busy2, done2});
    end
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h/%h want=0/0", rdata1, rdata2);
    end
    @(negedge clk); rst = 0;
    tick();
  endtask

  task automatic test_lat1_rw();
    logic [DW-1:0] d; logic v;
    wr(6'd5, 32'hDEADBEEF);
    rd1(6'd5, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat1_read got v=%b d=%h want v=1 d=deadbeef", v, d);
    end
    tick();
    checks++;
    if (rvalid1 !== 1'b0 || rdata1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lat1_hold got v=%b d=%h want v=0 d=deadbeef", rvalid1, rdata1);
    end
  endtask

  task automatic test_lat2_back_to_back();
    for (int i = 0; i < 4; i++) wr(AW'(i), 32'h10 + i);
    for (int i = 0; i < 4; i++) begin
      re = 1; raddr = AW'(i);
      tick();
      checks++;
      if (i == 0) begin
        if (rvalid2 !== 1'b0) begin
          errors++; $display("FAIL lat2_early got v=%b want v=0", rvalid2);
        end
      end else if (rvalid2 !== 1'b1 || rdata2 !== 32'h10 + i - 1) begin
        errors++; $display("FAIL lat2_beat%0d got v=%b d=%h want v=1 d=%h", i - 1, rvalid2, rdata2, 32'h10 + i - 1);
      end
    end
    re = 0;
    tick();
    checks++;
    if (rvalid2 !== 1'b1 || rdata2 !== 32'h13) begin
      errors++; $display("FAIL lat2_beat3 got v=%b d=%h want v=1 d=13", rvalid2, rdata2);
    end
    tick();
    checks++;
    if (rvalid2 !== 1'b0 || rdata2 !== 32'h13) begin
      errors++; $display("FAIL lat2_hold got v=%b d=%h want v=0 d=13", rvalid2, rdata2);
    end
  endtask

  // Runs a sweep already started; optionally drives user traffic throughout.
  task automatic run_sweep(input bit noisy, output int busy_cnt, output int done_at,
                           output int done_cnt, output int rv_cnt);
    busy_cnt = 0; done_at = -1; done_cnt = 0; rv_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy1) break;
      busy_cnt++;
      if (rvalid1 || rvalid2) rv_cnt++;
      if (done1) begin
        done_cnt++; done_at = busy_cnt;
        idle_inputs();
      end else if (noisy) begin
        we = 1; waddr = 6'd10; wdata = 32'h55; re = 1; raddr = 6'd10; zeroize = 1;
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL sweep_timeout busy still high after 200 cycles");
    end
  endtask

  task automatic test_zeroize();
    int bc, da, dc, rc;
    logic [DW-1:0] d; logic v;
    int bad;
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hFFFFFFFF);
    zeroize = 1;
    tick();
    zeroize = 0;
    checks++;
    if (busy1 !== 1'b1 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++; $display("FAIL zero_entry got busy=%b d=%h/%h want busy=1 d=0/0", busy1, rdata1, rdata2);
    end
    run_sweep(1'b0, bc, da, dc, rc);
    checks++;
    if (bc != 65 || da != 65 || dc != 1) begin
      errors++; $display("FAIL zero_timing got busy=%0d done_at=%0d pulses=%0d want 65/65/1", bc, da, dc);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd1(AW'(i), d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL zero_read@%0d got v=%b d=%h want v=1 d=0", i, v, d);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int bc, da, dc, rc;
    logic [DW-1:0] d; logic v;
    zeroize = 1;
    tick();
    run_sweep(1'b1, bc, da, dc, rc);
    checks++;
    if (rc != 0) begin
      errors++; $display("FAIL busy_rvalid got %0d valid beats want 0", rc);
    end
    checks++;
    if (bc != 65 || dc != 1) begin
      errors++; $display("FAIL busy_restart got busy=%0d pulses=%0d want 65/1", bc, dc);
    end
    rd1(6'd10, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL busy_write got v=%b d=%h want v=1 d=0", v, d);
    end
  endtask

  task automatic test_zeroize_priority();
    logic [DW-1:0] d; logic v;
    wr(6'd3, 32'h33);
    // Same-cycle write/read with zeroize: both must be dropped.
    zeroize = 1; we = 1; waddr = 6'd3; wdata = 32'h77; re = 1; raddr = 6'd3;
    tick();
    idle_inputs();
    checks++;
    if (rvalid1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL prio_read got v=%b busy=%b want v=0 busy=1", rvalid1, busy1);
    end
    for (int k = 0; k < 80 && busy1; k++) tick();
    rd1(6'd3, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL prio_write got d=%h want 0", d);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] d; logic v;
    logic [DW-1:0] exp;
`ifdef ABR_RAM_WR_BYPASS_EN
    exp = 32'h2;
`else
    exp = 32'h1;
`endif
    wr(6'd7, 32'h1);
    we = 1; waddr = 6'd7; wdata = 32'h2; re = 1; raddr = 6'd7;
    tick();
    idle_inputs();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== exp) begin
      errors++; $display("FAIL bypass got v=%b d=%h want v=1 d=%h", rvalid1, rdata1, exp);
    end
    rd1(6'd7, d, v);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL bypass_wr got d=%h want 2", d);
    end
    // Different addresses in the same cycle are independent.
    wr(6'd8, 32'hABCD);
    we = 1; waddr = 6'd9; wdata = 32'h99; re = 1; raddr = 6'd8;
    tick();
    idle_inputs();
    rd1(6'd9, d, v);
    checks++;
    if (rdata1 !== 32'h99) begin
      errors++; $display("FAIL indep_wr got d=%h want 99", d);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [DW-1:0] d; logic v;
    for (int i = 0; i < 26; i++) wr(AW'(i), 32'hFFFFFFFF);
    wr(6'd40, 32'hA5A5A5A5);
    re = 1; raddr = 6'd40;
    tick();
    re = 0;
    zeroize = 1;
    tick();
    zeroize = 0;
    // Counter now 0; after 20 edges words 0..19 are cleared and counter is 20.
    for (int k = 0; k < 20; k++) tick();
    #1 rst = 1;
    #1;
    checks++;
    if ({rvalid1, busy1, done1, rvalid2, busy2, done2} !== 6'b0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs got flags=%b d=%h/%h want 0", {rvalid1, busy1, done1, rvalid2, busy2, done2}, rdata1, rdata2);
    end
    checks++;
    if (dut1.u_ctrl.state_q !== abr_ram_pkg::ZRAM_IDLE) begin
      errors++; $display("FAIL rst_mid_state got %0d want IDLE", dut1.u_ctrl.state_q);
    end
    @(negedge clk); rst = 0;
    tick();
    rd1(6'd0, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL rst_mid_w0 got v=%b d=%h want v=1 d=0", v, d);
    end
    rd1(6'd19, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rst_mid_w19 got d=%h want 0", d);
    end
    rd1(6'd20, d, v);
    checks++;
    if (d !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL rst_mid_w20 got d=%h want ffffffff", d);
    end
    rd1(6'd40, d, v);
    checks++;
    if (d !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL rst_mid_w40 got d=%h want a5a5a5a5", d);
    end
  endtask

  initial begin
    test_reset();
    test_lat1_rw();
    test_lat2_back_to_back();
    test_zeroize();
    test_busy_ignore();
    test_zeroize_priority();
    test_bypass();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
